// File: rtl/screens_sequencer.sv
// ---------------------------------------------------------------------------
// screens_sequencer
// Game screen sequencer: title -> play -> winner screen -> title.
// Screens are timed in video frames (startOfFrame pulses). A one-cycle
// game_reset pulse re-initialises the game objects on every new game, and
// a saturating win counter is kept per player.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   startOfFrame    one-cycle pulse per video frame
//   start_key       start/enter key level (already synchronised)
//   green_win       green player won (level or pulse)
//   yellow_win      yellow player won (level or pulse)
//   initial_screen  title screen select        (registered)
//   green_screen    green-wins screen select   (registered)
//   yellow_screen   yellow-wins screen select  (registered)
//   game_active     high while playing         (registered)
//   game_reset      one-cycle pulse on entry to play (registered)
//   green_wins      green win count, saturates at 15
//   yellow_wins     yellow win count, saturates at 15
// ---------------------------------------------------------------------------
module screens_sequencer #(
  parameter int unsigned MIN_INIT_FRAMES = 30,
  parameter int unsigned WIN_HOLD_FRAMES = 180,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       start_key,
  input  logic       green_win,
  input  logic       yellow_win,
  output logic       initial_screen,
  output logic       green_screen,
  output logic       yellow_screen,
  output logic       game_active,
  output logic       game_reset,
  output logic [3:0] green_wins,
  output logic [3:0] yellow_wins
);

  localparam int unsigned WINS_W = 4;
  localparam logic [CNT_W-1:0]  INIT_LIMIT = CNT_W'(MIN_INIT_FRAMES);
  localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(WIN_HOLD_FRAMES - 1);
  localparam logic [WINS_W-1:0] WINS_MAX   = '1;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_PLAY   = 2'd1,
    S_GREEN  = 2'd2,
    S_YELLOW = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] frame_cnt;
  logic             key_d;
  logic             key_edge;
  logic             init_ready;
  logic             hold_done;
  logic             skip_ok;

  // Rising edge of the start key; key_d resets high so a held key is not an edge.
  always_comb begin
    key_edge   = start_key & ~key_d;
    init_ready = (frame_cnt == INIT_LIMIT);
    hold_done  = startOfFrame & (frame_cnt == HOLD_LAST);
    skip_ok    = key_edge & (frame_cnt >= INIT_LIMIT);
  end

  // Sequencer: state, frame timer, registered screen flags and win counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_INIT;
      frame_cnt      <= '0;
      key_d          <= 1'b1;
      initial_screen <= 1'b1;
      green_screen   <= 1'b0;
      yellow_screen  <= 1'b0;
      game_active    <= 1'b0;
      game_reset     <= 1'b0;
      green_wins     <= '0;
      yellow_wins    <= '0;
    end else begin
      key_d      <= start_key;
      game_reset <= 1'b0;
      case (state)
        S_INIT: begin
          // Key edges before the title has shown long enough are dropped.
          if (init_ready && key_edge) begin
            state          <= S_PLAY;
            frame_cnt      <= '0;
            initial_screen <= 1'b0;
            game_active    <= 1'b1;
            game_reset     <= 1'b1;
          end else if (startOfFrame && (frame_cnt < INIT_LIMIT)) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
        end
        S_PLAY: begin
          // Green wins a same-cycle tie.
          if (green_win) begin
            state        <= S_GREEN;
            frame_cnt    <= '0;
            green_screen <= 1'b1;
            game_active  <= 1'b0;
            if (green_wins != WINS_MAX) green_wins <= green_wins + WINS_W'(1);
          end else if (yellow_win) begin
            state         <= S_YELLOW;
            frame_cnt     <= '0;
            yellow_screen <= 1'b1;
            game_active   <= 1'b0;
            if (yellow_wins != WINS_MAX) yellow_wins <= yellow_wins + WINS_W'(1);
          end
        end
        S_GREEN, S_YELLOW: begin
          // Auto-return on the last hold frame, or early skip by key.
          if (hold_done || skip_ok) begin
            state          <= S_INIT;
            frame_cnt      <= '0;
            initial_screen <= 1'b1;
            green_screen   <= 1'b0;
            yellow_screen  <= 1'b0;
          end else if (startOfFrame && (frame_cnt < HOLD_LAST)) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
        end
        default: begin
          state          <= S_INIT;
          frame_cnt      <= '0;
          initial_screen <= 1'b1;
          green_screen   <= 1'b0;
          yellow_screen  <= 1'b0;
          game_active    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_screens_sequencer.sv
// ---------------------------------------------------------------------------
// tb_screens_sequencer
// Directed scenarios plus a randomized phase, checked every cycle against a
// screen-level reference model, with literal expectations at key moments.
// ---------------------------------------------------------------------------
module tb_screens_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       start_key = 1'b1;
  logic       green_win = 1'b0;
  logic       yellow_win = 1'b0;
  logic       initial_screen, green_screen, yellow_screen;
  logic       game_active, game_reset;
  logic [3:0] green_wins, yellow_wins;

  int n_chk  = 0;
  int n_fail = 0;

  screens_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .start_key      (start_key),
    .green_win      (green_win),
    .yellow_win     (yellow_win),
    .initial_screen (initial_screen),
    .green_screen   (green_screen),
    .yellow_screen  (yellow_screen),
    .game_active    (game_active),
    .game_reset     (game_reset),
    .green_wins     (green_wins),
    .yellow_wins    (yellow_wins)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: screen = 0 title, 1 play, 2 green, 3 yellow.
  // frames counts frame pulses seen on the current screen (unbounded).
  int  m_screen = 0;
  int  m_frames = 0;
  bit  m_prev_key = 1'b1;
  int  m_green = 0;
  int  m_yellow = 0;
  bit  m_new_game = 1'b0;
  bit  armed = 1'b0;

  always @(posedge clk) begin
    bit pressed;
    int nxt;
    pressed = start_key && !m_prev_key;
    if (reset) begin
      m_screen = 0; m_frames = 0; m_prev_key = 1'b1;
      m_green = 0; m_yellow = 0; m_new_game = 1'b0;
      armed = 1'b1;
    end else begin
      nxt = m_screen;
      m_new_game = 1'b0;
      if (m_screen == 0) begin
        if (m_frames >= 30 && pressed) begin nxt = 1; m_new_game = 1'b1; end
      end else if (m_screen == 1) begin
        if (green_win) begin nxt = 2; m_green = (m_green < 15) ? m_green + 1 : 15; end
        else if (yellow_win) begin nxt = 3; m_yellow = (m_yellow < 15) ? m_yellow + 1 : 15; end
      end else begin
        if ((startOfFrame && m_frames + 1 == 180) || (pressed && m_frames >= 30)) nxt = 0;
      end
      if (nxt != m_screen) begin
        m_screen = nxt; m_frames = 0;
      end else if (startOfFrame) begin
        m_frames = m_frames + 1;
      end
      m_prev_key = start_key;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("initial_screen", int'(initial_screen), int'(m_screen == 0));
      chk("green_screen",   int'(green_screen),   int'(m_screen == 2));
      chk("yellow_screen",  int'(yellow_screen),  int'(m_screen == 3));
      chk("game_active",    int'(game_active),    int'(m_screen == 1));
      chk("game_reset",     int'(game_reset),     int'(m_new_game));
      chk("green_wins",     int'(green_wins),     m_green);
      chk("yellow_wins",    int'(yellow_wins),    m_yellow);
    end
  end

  task automatic cyc(input logic r, input logic s, input logic k, input logic g, input logic y);
    @(negedge clk);
    reset = r; startOfFrame = s; start_key = k; green_win = g; yellow_win = y;
  endtask

  task automatic run_frames(input int n, input logic k, input logic g, input logic y);
    repeat (n) begin
      cyc(1'b0, 1'b1, k, g, y);
      cyc(1'b0, 1'b0, k, g, y);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic new_game();
    run_frames(31, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic skip_winner();
    run_frames(31, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int ret;
    bit k;
    // Reset with the key held; holding it for 40 frames is not an edge.
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("reset_initial", int'(initial_screen), 1);
    chk("reset_wins", int'(green_wins) + int'(yellow_wins), 0);
    run_frames(40, 1'b1, 1'b0, 1'b0);
    settle();
    chk("held_key_init", int'(initial_screen), 1);
    chk("held_key_active", int'(game_active), 0);

    // Release and press: play starts with a single game_reset cycle.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("start_active", int'(game_active), 1);
    chk("start_game_reset", int'(game_reset), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("game_reset_one_cycle", int'(game_reset), 0);

    // Tie: green has priority.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    settle();
    chk("tie_green_screen", int'(green_screen), 1);
    chk("tie_green_wins", int'(green_wins), 1);
    chk("tie_yellow_wins", int'(yellow_wins), 0);

    // Winner screen without a key edge returns on the 180th frame pulse.
    ret = 0;
    for (int i = 1; i <= 200; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      if (initial_screen) begin ret = i; break; end
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("hold_return_frame", ret, 180);

    // Early press on the title is dropped; press after 31 frames starts play.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frames(10, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("early_press_ignored", int'(game_active), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frames(21, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("press_31_init", int'(initial_screen), 0);
    chk("press_31_active", int'(game_active), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Yellow win, then key skip at frame 35.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("yellow_screen", int'(yellow_screen), 1);
    chk("yellow_wins_1", int'(yellow_wins), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frames(35, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("skip_return", int'(initial_screen), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fifteen more green wins (16 total) saturate at 15.
    repeat (15) begin
      new_game();
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      skip_winner();
    end
    settle();
    chk("green_saturate", int'(green_wins), 15);

    // Reset while on the yellow screen.
    new_game();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("reset_mid_init", int'(initial_screen), 1);
    chk("reset_mid_yellow", int'(yellow_screen), 0);
    chk("reset_mid_green_wins", int'(green_wins), 0);
    chk("reset_mid_yellow_wins", int'(yellow_wins), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // A held yellow_win counts once across winner and title screens.
    new_game();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frames(180, 1'b0, 1'b0, 1'b1);
    run_frames(35, 1'b0, 1'b0, 1'b1);
    settle();
    chk("held_win_once", int'(yellow_wins), 1);
    chk("held_win_title", int'(initial_screen), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized phase, checked by the model every cycle.
    k = 1'b0;
    repeat (6000) begin
      if ($urandom_range(0, 7) == 0) k = !k;
      cyc(1'($urandom_range(0, 2999) == 0), 1'($urandom_range(0, 2) == 0), k,
          1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 49) == 0));
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
